seq_multiplier: RTL

Parametrised sequential shift-and-add multiplier. It is the iterative successor to the team's fixed 4x4 combinational array multiplier. It trades area for latency: one partial product is accumulated per clock. It handles WIDTH x WIDTH operands with a per-operation unsigned/signed mode and a start/busy/done handshake, and sits between a register-file style operand source and a result consumer.

---
 rtl/seq_multiplier.sv | 98 +++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier: one partial product per clock, WIDTH x WIDTH -> 2*WIDTH,
// with per-operation unsigned / two's-complement mode and a start/busy/done handshake.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Handshake: start (with signed_mode/a/b) is accepted only on an edge where the block is
    // idle (busy=0); busy stays high from the accepting edge through the done cycle, done is a
    // single-cycle pulse and p is valid from that cycle until the next completion.
    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;
    logic               last;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Signed operands are reduced to magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (signed_mode && a[WIDTH-1]) a_mag = -a;
        if (signed_mode && b[WIDTH-1]) b_mag = -b;
    end

    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplier[0]) sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_next = {sum, acc[WIDTH-1:1]};
        result   = neg ? -acc_next : acc_next;
        last     = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        p     <= result;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
